// File: rtl/cordic_post_scale.sv
// CORDIC gain compensation: multiply by 1/K, round, saturate.
// Two-stage stallable pipeline with drop and saturation counters.
module cordic_post_scale #(
   parameter int SIZE      = 16,
   parameter int GAIN      = 39797,
   parameter int GAIN_FRAC = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   input  logic signed [SIZE:0]   in_x,
   input  logic signed [SIZE:0]   in_y,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [SIZE-1:0] out_x,
   output logic signed [SIZE-1:0] out_y,
   output logic                   out_sat,
   output logic [15:0]            sat_count,
   output logic [15:0]            drop_count,
   input  logic                   clear_counts
);

   localparam int PW = SIZE + GAIN_FRAC + 2;

   localparam logic [GAIN_FRAC-1:0] GAIN_U = GAIN_FRAC'(GAIN);
   localparam logic signed [GAIN_FRAC:0] GAIN_S = {1'b0, GAIN_U};

   localparam logic signed [PW-1:0] RND  = PW'(1) << (GAIN_FRAC - 1);
   localparam logic signed [PW-1:0] MAXV = PW'((2 ** (SIZE - 1)) - 1);
   localparam logic signed [PW-1:0] MINV = ~MAXV;

   logic                   s1_valid_q;
   logic signed [PW-1:0]   s1_px_q, s1_py_q;
   logic signed [PW-1:0]   s1_px_d, s1_py_d;

   logic                   out_valid_q;
   logic signed [SIZE-1:0] out_x_q, out_y_q;
   logic                   out_sat_q;
   logic signed [SIZE-1:0] out_x_d, out_y_d;
   logic                   out_sat_d;

   logic [15:0] sat_cnt_q, sat_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic adv;
   logic sat_inc;
   logic drop_inc;

   // Round half toward +inf, then clamp; MSB of result flags a clip.
   function automatic logic [SIZE:0] rnd_sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = (p + RND) >>> GAIN_FRAC;
      if (r > MAXV) return {1'b1, MAXV[SIZE-1:0]};
      if (r < MINV) return {1'b1, MINV[SIZE-1:0]};
      return {1'b0, r[SIZE-1:0]};
   endfunction

   assign adv      = !out_valid_q || out_ready;
   assign sat_inc  = out_valid_q && out_ready && out_sat_q;
   assign drop_inc = in_valid && !adv;

   assign s1_px_d = PW'(in_x) * PW'(GAIN_S);
   assign s1_py_d = PW'(in_y) * PW'(GAIN_S);

   // Round/saturate both channels from the S1 products.
   always_comb begin
      logic [SIZE:0] rx, ry;
      rx = rnd_sat(s1_px_q);
      ry = rnd_sat(s1_py_q);
      out_x_d   = rx[SIZE-1:0];
      out_y_d   = ry[SIZE-1:0];
      out_sat_d = rx[SIZE] | ry[SIZE];
   end

   // Saturating event counters; clear wins over increment.
   always_comb begin
      sat_cnt_d  = sat_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (sat_inc && sat_cnt_q != 16'hFFFF)
         sat_cnt_d = sat_cnt_q + 16'd1;
      if (drop_inc && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;
      if (clear_counts) begin
         sat_cnt_d  = '0;
         drop_cnt_d = '0;
      end
   end

   // Pipeline shifts as a whole on adv; data only loads with a valid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_px_q     <= '0;
         s1_py_q     <= '0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_sat_q   <= 1'b0;
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         out_valid_q <= s1_valid_q;
         if (in_valid) begin
            s1_px_q <= s1_px_d;
            s1_py_q <= s1_py_d;
         end
         if (s1_valid_q) begin
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_sat_q <= out_sat_d;
         end
      end
   end

   // Counter state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sat_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         sat_cnt_q  <= sat_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;
   assign out_sat    = out_sat_q;
   assign sat_count  = sat_cnt_q;
   assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_cordic_post_scale.sv
// Directed bench for cordic_post_scale.
// Vector table plus stream, stall, counter and reset sequences.
module tb_cordic_post_scale;

   logic               clock = 1'b0;
   logic               reset_n;
   logic               in_valid;
   logic signed [16:0] in_x, in_y;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_x, out_y;
   logic               out_sat;
   logic [15:0]        sat_count, drop_count;
   logic               clear_counts;

   int n_chk  = 0;
   int n_fail = 0;

   cordic_post_scale dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_x        (in_x),
      .in_y        (in_y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_sat     (out_sat),
      .sat_count   (sat_count),
      .drop_count  (drop_count),
      .clear_counts(clear_counts)
   );

   always #5 clock = ~clock;

   typedef struct {
      int x;
      int y;
      int ex;
      int ey;
      int es;
   } vec_t;

   vec_t vt[8];

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: round(v/K) half toward +inf, clamped to 16-bit signed.
   function automatic int mdl(input int v, output int clip);
      longint r;
      r = (longint'(v) * 64'sd39797 + 64'sd32768) >>> 16;
      clip = 0;
      if (r > 32767) begin r = 32767; clip = 1; end
      if (r < -32768) begin r = -32768; clip = 1; end
      return int'(r);
   endfunction

   initial begin
      int exp_sat;
      int qx[$], qy[$], qs[$];
      int first, last, got;

      vt[0] = '{1000, -1000, 607, -607, 0};
      vt[1] = '{0, 0, 0, 0, 0};
      vt[2] = '{65535, -65536, 32767, -32768, 1};
      vt[3] = '{1, -1, 1, -1, 0};
      vt[4] = '{53960, -53961, 32767, -32768, 0};
      vt[5] = '{53961, 0, 32767, 0, 1};
      vt[6] = '{0, -53962, 0, -32768, 1};
      vt[7] = '{-3, 5, -2, 3, 0};

      reset_n = 1'b0;
      in_valid = 1'b0;
      in_x = '0;
      in_y = '0;
      out_ready = 1'b1;
      clear_counts = 1'b0;
      tick();
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_x", out_x, 0);
      chk("rst_y", out_y, 0);
      chk("rst_sat", out_sat, 0);
      chk("rst_satcnt", sat_count, 0);
      chk("rst_dropcnt", drop_count, 0);
      reset_n = 1'b1;
      tick();

      // Single samples through an idle pipe.
      exp_sat = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_x = 17'(vt[i].x);
         in_y = 17'(vt[i].y);
         tick();
         in_valid = 1'b0;
         chk("vec_lat1", out_valid, 0);
         tick();
         chk("vec_valid", out_valid, 1);
         chk("vec_x", out_x, vt[i].ex);
         chk("vec_y", out_y, vt[i].ey);
         chk("vec_sat", out_sat, vt[i].es);
         tick();
         exp_sat += vt[i].es;
         chk("vec_drain", out_valid, 0);
         chk("vec_hold_x", out_x, vt[i].ex);
         chk("vec_satcnt", sat_count, exp_sat);
      end

      // 20 back-to-back samples.
      first = -1;
      last = -1;
      got = 0;
      for (int c = 0; c < 30; c++) begin
         if (out_valid) begin
            if (first < 0) first = c;
            last = c;
            got++;
            if (qx.size() == 0) begin
               chk("stream_extra", got, 20);
            end else begin
               chk("stream_x", out_x, qx.pop_front());
               chk("stream_y", out_y, qy.pop_front());
               chk("stream_sat", out_sat, qs.pop_front());
            end
         end
         if (c < 20) begin
            int cx, cy, sx, sy;
            in_valid = 1'b1;
            in_x = 17'(c * 6000 - 65536);
            in_y = 17'(60000 - c * 5000);
            qx.push_back(mdl(c * 6000 - 65536, sx));
            qy.push_back(mdl(60000 - c * 5000, sy));
            qs.push_back(sx | sy);
            exp_sat += sx | sy;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      chk("stream_count", got, 20);
      chk("stream_first", first, 2);
      chk("stream_gapless", last - first, 19);
      chk("stream_drop", drop_count, 0);
      chk("stream_satcnt", sat_count, exp_sat);

      // Back-pressure for 5 cycles with input still arriving.
      in_valid = 1'b1;
      in_x = 17'sd1000;
      in_y = -17'sd1000;
      tick();
      in_x = -17'sd3;
      in_y = 17'sd5;
      tick();
      chk("stall_pre_valid", out_valid, 1);
      out_ready = 1'b0;
      in_x = 17'sd2000;
      in_y = 17'sd2000;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", out_valid, 1);
         chk("stall_x", out_x, 607);
         chk("stall_y", out_y, -607);
      end
      chk("stall_drop", drop_count, 5);
      out_ready = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("release_valid1", out_valid, 1);
      chk("release_x1", out_x, -2);
      chk("release_y1", out_y, 3);
      tick();
      chk("release_empty", out_valid, 0);
      chk("release_drop", drop_count, 5);

      // Saturation counter ceiling and clear priority.
      in_valid = 1'b1;
      in_x = 17'sd65535;
      in_y = '0;
      for (int k = 0; k < 70000; k++) tick();
      chk("satcnt_peak", sat_count, 16'hFFFF);
      chk("satcnt_xfer", out_valid && out_sat, 1);
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
      chk("clear_sat", sat_count, 0);
      chk("clear_drop", drop_count, 0);
      tick();
      chk("post_clear_sat", sat_count, 1);
      out_ready = 1'b0;
      tick();
      tick();
      chk("pre_rst_drop", drop_count, 2);

      // Asynchronous reset with two samples in flight.
      out_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_x", out_x, 0);
      chk("arst_sat", out_sat, 0);
      chk("arst_satcnt", sat_count, 0);
      chk("arst_dropcnt", drop_count, 0);
      in_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      in_valid = 1'b1;
      in_x = 17'sd1;
      in_y = -17'sd1;
      tick();
      in_valid = 1'b0;
      chk("arst_lat1", out_valid, 0);
      tick();
      chk("arst_out_valid", out_valid, 1);
      chk("arst_out_x", out_x, 1);
      chk("arst_out_y", out_y, -1);
      tick();
      chk("arst_drain", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
